// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin read arbiter in front of a single XIP SPI flash word reader.
// Optional per-port hit buffer enabled by defining SPIFLASH_ARB_HITBUF_EN.
module spi_flash_arbiter #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              resetq,
    // instruction-fetch port
    input  logic              i_rstrb,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_rbusy,
    // data-load port
    input  logic              d_rstrb,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       d_rdata,
    output logic              d_rbusy,
    // flash reader side
    output logic              f_rstrb,
    output logic [ADDR_W-1:0] f_word_address,
    input  logic [31:0]       f_rdata,
    input  logic              f_rbusy,
    // debug view of the sequencer state
    output logic [1:0]        dbg_state
);

    // Handshake: a port strobe is accepted only while that port has nothing
    // pending; rbusy stays high from the cycle after acceptance until the cycle
    // after the flash word has been captured into the port's rdata register.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              i_pend_q, i_pend_d;
    logic              d_pend_q, d_pend_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0] f_addr_q, f_addr_d;
    logic              i_hit, d_hit;

`ifdef SPIFLASH_ARB_HITBUF_EN
    logic [ADDR_W-1:0] i_tag_q, i_tag_d;
    logic [ADDR_W-1:0] d_tag_q, d_tag_d;
    logic              i_tval_q, i_tval_d;
    logic              d_tval_q, d_tval_d;

    always_comb begin
        i_hit = i_tval_q && (i_addr == i_tag_q);
        d_hit = d_tval_q && (d_addr == d_tag_q);
    end
`else
    always_comb begin
        i_hit = 1'b0;
        d_hit = 1'b0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        i_pend_d     = i_pend_q;
        d_pend_d     = d_pend_q;
        i_addr_d     = i_addr_q;
        d_addr_d     = d_addr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        f_addr_d     = f_addr_q;
`ifdef SPIFLASH_ARB_HITBUF_EN
        i_tag_d      = i_tag_q;
        d_tag_d      = d_tag_q;
        i_tval_d     = i_tval_q;
        d_tval_d     = d_tval_q;
`endif

        // A strobe while pending is a protocol violation and is dropped.
        if (i_rstrb && !i_pend_q && !i_hit) begin
            i_pend_d = 1'b1;
            i_addr_d = i_addr;
        end
        if (d_rstrb && !d_pend_q && !d_hit) begin
            d_pend_d = 1'b1;
            d_addr_d = d_addr;
        end

        case (state_q)
            S_IDLE: begin
                // f_rbusy gate also covers a stale transfer surviving our reset.
                if (!f_rbusy && (i_pend_q || d_pend_q)) begin
                    if (i_pend_q && d_pend_q) begin
                        grant_d = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
                    end else begin
                        grant_d = d_pend_q ? PORT_D : PORT_I;
                    end
                    f_addr_d = (grant_d == PORT_D) ? d_addr_q : i_addr_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!f_rbusy) begin
                    if (grant_q == PORT_D) begin
                        d_rdata_d = f_rdata;
                        d_pend_d  = 1'b0;
`ifdef SPIFLASH_ARB_HITBUF_EN
                        d_tag_d   = d_addr_q;
                        d_tval_d  = 1'b1;
`endif
                    end else begin
                        i_rdata_d = f_rdata;
                        i_pend_d  = 1'b0;
`ifdef SPIFLASH_ARB_HITBUF_EN
                        i_tag_d   = i_addr_q;
                        i_tval_d  = 1'b1;
`endif
                    end
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q      <= S_IDLE;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_I;
            i_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_addr_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            i_pend_q     <= i_pend_d;
            d_pend_q     <= d_pend_d;
            i_addr_q     <= i_addr_d;
            d_addr_q     <= d_addr_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            f_addr_q     <= f_addr_d;
        end
    end

`ifdef SPIFLASH_ARB_HITBUF_EN
    // Flash is read-only, so tags are only ever invalidated by reset.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            i_tag_q  <= '0;
            d_tag_q  <= '0;
            i_tval_q <= 1'b0;
            d_tval_q <= 1'b0;
        end else begin
            i_tag_q  <= i_tag_d;
            d_tag_q  <= d_tag_d;
            i_tval_q <= i_tval_d;
            d_tval_q <= d_tval_d;
        end
    end
`endif

    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign i_rbusy        = i_pend_q;
    assign d_rbusy        = d_pend_q;
    assign f_rstrb        = (state_q == S_ISSUE);
    assign f_word_address = f_addr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with a 64-cycle flash reader model and
// a scoreboard of expected flash addresses and per-port read data.
module tb_spi_flash_arbiter;
    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              resetq;
    logic              i_rstrb, d_rstrb;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [31:0]       i_rdata, d_rdata;
    logic              i_rbusy, d_rbusy;
    logic              f_rstrb;
    logic [ADDR_W-1:0] f_word_address;
    logic [31:0]       f_rdata;
    logic              f_rbusy;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_f_q[$];
    logic [31:0]       exp_i_q[$];
    logic [31:0]       exp_d_q[$];

    spi_flash_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetq(resetq),
        .i_rstrb(i_rstrb), .i_addr(i_addr), .i_rdata(i_rdata), .i_rbusy(i_rbusy),
        .d_rstrb(d_rstrb), .d_addr(d_addr), .d_rdata(d_rdata), .d_rbusy(d_rbusy),
        .f_rstrb(f_rstrb), .f_word_address(f_word_address),
        .f_rdata(f_rdata), .f_rbusy(f_rbusy), .dbg_state(dbg_state)
    );

    // clock / flash reader model (no reset, busy for 64 cycles after a strobe)
    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input logic [ADDR_W-1:0] a);
        if (a == 22'h000010) return 32'hDEADBEEF;
        return 32'h5A00_0000 | {10'h0, a};
    endfunction

    int          fcnt = 0;
    logic [31:0] fmem = 32'h0;
    always @(posedge clk) begin
        if (f_rstrb) begin
            fcnt <= 64;
            fmem <= fdata(f_word_address);
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
        end
    end
    assign f_rbusy = (fcnt != 0);
    assign f_rdata = fmem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    task automatic monitor();
        logic i_prev = 1'b0;
        logic d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetq) begin
                i_prev = 1'b0;
                d_prev = 1'b0;
            end else begin
                if (i_prev && !i_rbusy) begin
                    if (exp_i_q.size() == 0) check("i_unexpected_capture", i_rdata, 32'hx);
                    else check("i_rdata", i_rdata, exp_i_q.pop_front());
                end
                if (d_prev && !d_rbusy) begin
                    if (exp_d_q.size() == 0) check("d_unexpected_capture", d_rdata, 32'hx);
                    else check("d_rdata", d_rdata, exp_d_q.pop_front());
                end
                if (f_rstrb) begin
                    if (exp_f_q.size() == 0) check("f_unexpected_strobe", {10'h0, f_word_address}, 32'hx);
                    else check("f_word_address", {10'h0, f_word_address}, {10'h0, exp_f_q.pop_front()});
                end
                i_prev = i_rbusy;
                d_prev = d_rbusy;
            end
        end
    endtask

    // driver tasks: strobe is high for the cycle following the next edge (cycle 0)
    task automatic strobe(input logic ie, input logic [ADDR_W-1:0] ia,
                          input logic de, input logic [ADDR_W-1:0] da);
        @(posedge clk);
        #1;
        i_rstrb = ie; i_addr = ia;
        d_rstrb = de; d_addr = da;
        @(posedge clk);
        #1;
        i_rstrb = 1'b0;
        d_rstrb = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((i_rbusy || d_rbusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, (i_rbusy || d_rbusy)}, 32'h0);
    endtask

    initial begin
        int ib_err, fr_err, i_fall, d_fall, busy_cnt, frs_cnt, last_busy, first_frs, viol;
        resetq = 1'b0;
        i_rstrb = 1'b0; d_rstrb = 1'b0;
        i_addr = '0; d_addr = '0;
        fork
            monitor();
        join_none

        // reset values
        repeat (3) @(negedge clk);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_busy", {30'h0, i_rbusy, d_rbusy}, 32'h0);
        check("rst_f_rstrb", {31'h0, f_rstrb}, 32'h0);
        check("rst_f_addr", {10'h0, f_word_address}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        @(posedge clk);
        #1 resetq = 1'b1;

        // single uncontended miss: exact cycle timing
        exp_f_q.push_back(22'h000010);
        exp_i_q.push_back(32'hDEADBEEF);
        strobe(1'b1, 22'h000010, 1'b0, '0);
        ib_err = 0; fr_err = 0;
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            if (i_rbusy !== (c <= 67)) ib_err++;
            if (f_rstrb !== (c == 2)) fr_err++;
        end
        check("t1_i_rbusy_window_errs", ib_err, 0);
        check("t1_f_rstrb_window_errs", fr_err, 0);
        check("t1_i_rdata_c68", i_rdata, 32'hDEADBEEF);

        // simultaneous requests: data wins first tie, instruction 67 cycles later
        exp_f_q.push_back(22'h000002);
        exp_f_q.push_back(22'h000001);
        exp_d_q.push_back(fdata(22'h000002));
        exp_i_q.push_back(fdata(22'h000001));
        strobe(1'b1, 22'h000001, 1'b1, 22'h000002);
        i_fall = 0; d_fall = 0;
        for (int c = 1; c <= 300 && (i_fall == 0 || d_fall == 0); c++) begin
            @(negedge clk);
            if (!d_rbusy && d_fall == 0) d_fall = c;
            if (!i_rbusy && i_fall == 0) i_fall = c;
        end
        check("t2_d_fall_cycle", d_fall, 68);
        check("t2_i_fall_cycle", i_fall, 135);

        // repeated ties alternate D, I with no starvation
        for (int r = 0; r < 4; r++) begin
            exp_f_q.push_back(22'h000100 + 22'(r));
            exp_f_q.push_back(22'h000200 + 22'(r));
            exp_d_q.push_back(fdata(22'h000100 + 22'(r)));
            exp_i_q.push_back(fdata(22'h000200 + 22'(r)));
            strobe(1'b1, 22'h000200 + 22'(r), 1'b1, 22'h000100 + 22'(r));
            wait_idle("t3_round_done", 300);
        end

        // repeated read of the same data word
        exp_f_q.push_back(22'h000040);
        exp_d_q.push_back(fdata(22'h000040));
        strobe(1'b0, '0, 1'b1, 22'h000040);
        wait_idle("t4_first_done", 200);
`ifndef SPIFLASH_ARB_HITBUF_EN
        exp_f_q.push_back(22'h000040);
        exp_d_q.push_back(fdata(22'h000040));
`endif
        strobe(1'b0, '0, 1'b1, 22'h000040);
        busy_cnt = 0; frs_cnt = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (d_rbusy) busy_cnt++;
            if (f_rstrb) frs_cnt++;
        end
`ifdef SPIFLASH_ARB_HITBUF_EN
        check("t4_hit_busy_cycles", busy_cnt, 0);
        check("t4_hit_f_strobes", frs_cnt, 0);
`else
        check("t4_miss_busy_cycles", busy_cnt, 67);
        check("t4_miss_f_strobes", frs_cnt, 1);
`endif
        check("t4_d_rdata", d_rdata, fdata(22'h000040));

        // reset in the middle of a flash transfer
        exp_f_q.push_back(22'h000300);
        strobe(1'b1, 22'h000300, 1'b0, '0);
        repeat (29) @(negedge clk);
        #1 resetq = 1'b0;
        #1;
        check("t5_rst_i_rdata", i_rdata, 32'h0);
        check("t5_rst_d_rdata", d_rdata, 32'h0);
        check("t5_rst_busy", {30'h0, i_rbusy, d_rbusy}, 32'h0);
        check("t5_rst_f_rstrb", {31'h0, f_rstrb}, 32'h0);
        check("t5_rst_f_addr", {10'h0, f_word_address}, 32'h0);
        check("t5_flash_still_busy", {31'h0, f_rbusy}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 resetq = 1'b1;
        exp_f_q.push_back(22'h000301);
        exp_i_q.push_back(fdata(22'h000301));
        strobe(1'b1, 22'h000301, 1'b0, '0);
        last_busy = 0; first_frs = 0; viol = 0; i_fall = 0;
        for (int c = 1; c <= 200 && i_fall == 0; c++) begin
            @(negedge clk);
            if (f_rstrb && f_rbusy) viol++;
            if (f_rstrb && first_frs == 0) first_frs = c;
            if (f_rbusy && first_frs == 0) last_busy = c;
            if (!i_rbusy) i_fall = c;
        end
        check("t5_strobe_while_busy", viol, 0);
        check("t5_issue_after_stale", {31'h0, (first_frs > last_busy) && (last_busy > 0)}, 32'h1);
        check("t5_completed", {31'h0, (i_fall != 0)}, 32'h1);
        check("t5_i_rdata", i_rdata, fdata(22'h000301));

        // strobe while pending is ignored
        exp_f_q.push_back(22'h000050);
        exp_d_q.push_back(fdata(22'h000050));
        strobe(1'b0, '0, 1'b1, 22'h000050);
        repeat (5) @(negedge clk);
        strobe(1'b0, '0, 1'b1, 22'h000051);
        wait_idle("t6_done", 200);
        repeat (10) @(negedge clk);
        check("t6_d_rdata", d_rdata, fdata(22'h000050));
        check("t6_d_rbusy_after", {31'h0, d_rbusy}, 32'h0);

        check("end_exp_f_left", exp_f_q.size(), 0);
        check("end_exp_i_left", exp_i_q.size(), 0);
        check("end_exp_d_left", exp_d_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
